// File: rtl/register_sequencer.sv
// Expands one accepted command into a train of single-cycle strobes for a 4-bit universal register.
// Strobes start the cycle after acceptance; done follows the last strobe; cmd_ready returns the cycle after done.
module register_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_abort,
    input  logic [3:0]       reg_q,
    output logic             cl,
    output logic             ld,
    output logic [3:0]       ld_data,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             sl,
    output logic             ir,
    output logic             il,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [2:0]       op_q;
    logic [3:0]       data_q;
    logic [CNT_W-1:0] rem_q;
    logic [5:0]       stb_q;
    logic             acc_rep;
    logic             acc_zero;

    // Strobe order in the mask: {cl, ld, inc, dec, sr, sl}
    function automatic logic [5:0] strobe_of(input logic [2:0] op);
        case (op)
            OP_CLR:         strobe_of = 6'b100000;
            OP_LOAD:        strobe_of = 6'b010000;
            OP_INC:         strobe_of = 6'b001000;
            OP_DEC:         strobe_of = 6'b000100;
            OP_SHR, OP_ROR: strobe_of = 6'b000010;
            OP_SHL:         strobe_of = 6'b000001;
            default:        strobe_of = 6'b000000;
        endcase
    endfunction

    assign acc_rep  = (cmd_op >= OP_INC);
    assign acc_zero = (cmd_op == OP_NOP) || (acc_rep && (cmd_cnt == '0));

    assign {cl, ld, inc, dec, sr, sl} = stb_q;

    // Rotate feeds the current LSB back in; it must track reg_q within the strobe cycle.
    assign ir = sr & ((op_q == OP_ROR) ? reg_q[0] : data_q[0]);
    assign il = sl & data_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            op_q      <= '0;
            data_q    <= '0;
            rem_q     <= '0;
            stb_q     <= '0;
            ld_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        if (acc_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                            rem_q <= '0;
                        end else begin
                            state   <= EXEC;
                            busy    <= 1'b1;
                            stb_q   <= strobe_of(cmd_op);
                            ld_data <= (cmd_op == OP_LOAD) ? cmd_data : 4'h0;
                            // Remaining strobes after the one issued on this edge
                            rem_q   <= acc_rep ? (cmd_cnt - CNT_ONE) : '0;
                        end
                    end
                end
                EXEC: begin
                    if (cmd_abort || (rem_q == '0)) begin
                        state   <= DONE;
                        stb_q   <= '0;
                        ld_data <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= cmd_abort;
                    end else begin
                        rem_q <= rem_q - CNT_ONE;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    stb_q     <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit universal register.
module tb_register_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_data = '0;
    logic [3:0] cmd_cnt = '0;
    logic       cmd_abort = 1'b0;
    logic [3:0] reg_q;
    logic       cl, ld, inc, dec, sr, sl, ir, il, busy, done, aborted;
    logic [3:0] ld_data;

    int checks = 0;
    int failures = 0;

    register_sequencer #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_abort(cmd_abort),
        .reg_q(reg_q), .cl(cl), .ld(ld), .ld_data(ld_data), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .ir(ir), .il(il), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Behavioural universal register fed by the strobes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   reg_q <= 4'h0;
        else if (cl)  reg_q <= 4'h0;
        else if (ld)  reg_q <= ld_data;
        else if (inc) reg_q <= reg_q + 4'h1;
        else if (dec) reg_q <= reg_q - 4'h1;
        else if (sr)  reg_q <= {ir, reg_q[3:1]};
        else if (sl)  reg_q <= {reg_q[2:0], il};
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] cnt;
        int         abort_at;
        logic [5:0] kind;
        int         nstr;
        int         done_cyc;
        logic [3:0] reg_exp;
        int         abt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nstr = 0;
        int done_cyc = -1;
        int abt = 0;
        int bad = 0;
        int rdy_after = 0;
        int got_rdy = 0;
        logic [5:0] s;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got_rdy = 1;
                break;
            end
        end
        chk($sformatf("v%0d ready_before", idx), got_rdy, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_cnt   = v.cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s = {cl, ld, inc, dec, sr, sl};
            if (s != 6'b0) begin
                nstr++;
                if (s != v.kind) bad++;
                if (!busy || cmd_ready || done) bad++;
            end
            if (ld && ld_data != v.data) bad++;
            if (!ld && ld_data != 4'h0) bad++;
            if (sr && v.op == 3'd7 && ir != reg_q[0]) bad++;
            if (sr && v.op == 3'd5 && ir != v.data[0]) bad++;
            if (sl && il != v.data[0]) bad++;
            if ((!sr && ir) || (!sl && il)) bad++;
            if (done) begin
                done_cyc = k;
                abt = aborted;
                if (busy || cmd_ready) bad++;
                chk($sformatf("v%0d reg", idx), reg_q, v.reg_exp);
                @(negedge clk);
                rdy_after = cmd_ready;
                if (done) bad++;
                break;
            end
            cmd_abort = (k == v.abort_at);
        end
        cmd_abort = 1'b0;
        chk($sformatf("v%0d strobes", idx), nstr, v.nstr);
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.done_cyc);
        chk($sformatf("v%0d aborted", idx), abt, v.abt);
        chk($sformatf("v%0d ready_after_done", idx), rdy_after, 1);
        chk($sformatf("v%0d cycle_rules", idx), bad, 0);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt,
                                input int abort_at, input logic [5:0] kind, input int nstr,
                                input int done_cyc, input logic [3:0] reg_exp, input int abt);
        vec_t v;
        v.op = op; v.data = data; v.cnt = cnt; v.abort_at = abort_at; v.kind = kind;
        v.nstr = nstr; v.done_cyc = done_cyc; v.reg_exp = reg_exp; v.abt = abt;
        return v;
    endfunction

    initial begin
        //             op    data  cnt  abt  kind       n   done reg  aborted
        vecs[0]  = mk(3'd2, 4'hA, 4'd0, 0, 6'b010000, 1,  2, 4'hA, 0);
        vecs[1]  = mk(3'd2, 4'hE, 4'd0, 0, 6'b010000, 1,  2, 4'hE, 0);
        vecs[2]  = mk(3'd3, 4'h0, 4'd3, 0, 6'b001000, 3,  4, 4'h1, 0);
        vecs[3]  = mk(3'd2, 4'h3, 4'd0, 0, 6'b010000, 1,  2, 4'h3, 0);
        vecs[4]  = mk(3'd7, 4'h0, 4'd1, 0, 6'b000010, 1,  2, 4'h9, 0);
        vecs[5]  = mk(3'd6, 4'h0, 4'd2, 0, 6'b000001, 2,  3, 4'h4, 0);
        vecs[6]  = mk(3'd5, 4'h1, 4'd0, 0, 6'b000010, 0,  1, 4'h4, 0);
        vecs[7]  = mk(3'd0, 4'hF, 4'd7, 0, 6'b000000, 0,  1, 4'h4, 0);
        vecs[8]  = mk(3'd1, 4'h6, 4'd5, 0, 6'b100000, 1,  2, 4'h0, 0);
        vecs[9]  = mk(3'd4, 4'h0, 4'd2, 0, 6'b000100, 2,  3, 4'hE, 0);
        vecs[10] = mk(3'd2, 4'h0, 4'd0, 0, 6'b010000, 1,  2, 4'h0, 0);
        vecs[11] = mk(3'd5, 4'h1, 4'd3, 0, 6'b000010, 3,  4, 4'hE, 0);
        vecs[12] = mk(3'd7, 4'h0, 4'd4, 0, 6'b000010, 4,  5, 4'hE, 0);
        vecs[13] = mk(3'd3, 4'h0, 4'd15, 0, 6'b001000, 15, 16, 4'hD, 0);
        vecs[14] = mk(3'd2, 4'h5, 4'd0, 0, 6'b010000, 1,  2, 4'h5, 0);
        vecs[15] = mk(3'd4, 4'h0, 4'd10, 4, 6'b000100, 4,  5, 4'h1, 1);
        vecs[16] = mk(3'd2, 4'h9, 4'd0, 1, 6'b010000, 1,  2, 4'h9, 1);
        vecs[17] = mk(3'd4, 4'h0, 4'd0, 0, 6'b000100, 0,  1, 4'h9, 0);

        #12;
        chk("reset_ready", cmd_ready, 1);
        chk("reset_outputs", {cl, ld, inc, dec, sr, sl, ir, il, busy, done, aborted}, 0);
        chk("reset_ld_data", ld_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort while idle must be ignored
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("idle_abort_ignored", {cmd_ready, busy, done, aborted}, 4'b1000);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of INC cnt=8
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 4'd8; cmd_data = 4'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_inc_active", {inc, busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_strobes_drop", {cl, ld, inc, dec, sr, sl, busy, done}, 0);
        chk("rst_ready", cmd_ready, 1);
        begin
            int seen_done = 0;
            repeat (3) begin
                @(negedge clk);
                if (done) seen_done = 1;
            end
            rst_n = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done) seen_done = 1;
            end
            chk("rst_no_done", seen_done, 0);
        end
        chk("rst_ready_after", cmd_ready, 1);
        run_vec(mk(3'd2, 4'h7, 4'd0, 0, 6'b010000, 1, 2, 4'h7, 0), 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
